// File: rtl/tree_search_ctrl_if.sv
// Request/result and node-memory signals of the tree search controller.
// The master side issues searches and serves the node memory; the slave side is the controller.
interface tree_search_ctrl_if #(
  parameter int D = 8,
  parameter int A = 8
);
  logic         start;
  logic [D-1:0] key;
  logic [A-1:0] mem_addr;
  logic         mem_rd;
  logic [D-1:0] mem_data;
  logic         busy;
  logic         done;
  logic         found;
  logic [A-1:0] found_addr;

  modport master (
    output start, key, mem_data,
    input  mem_addr, mem_rd, busy, done, found, found_addr
  );

  modport slave (
    input  start, key, mem_data,
    output mem_addr, mem_rd, busy, done, found, found_addr
  );
endinterface

// File: rtl/tree_search_ctrl.sv
// Binary-search walk over a heap-ordered tree held in a synchronous node memory.
// Define TREE_SEARCH_STEP_CNT_EN to add the steps output (CMP cycles of the current search).
//
// state | meaning
// IDLE  | waiting for start
// READ  | node read strobed at addr (suppressed for an EMPTY key)
// CMP   | node value compared against captured key
// DONE  | one-cycle completion pulse
module tree_search_ctrl #(
  parameter int           D     = 8,
  parameter int           A     = 8,
  parameter logic [D-1:0] EMPTY = {D{1'b1}}
) (
  input logic               clk,
  input logic               rst_n,
  tree_search_ctrl_if.slave bus
`ifdef TREE_SEARCH_STEP_CNT_EN
  ,
  output logic [A-1:0]      steps
`endif
);

  typedef enum logic [1:0] {IDLE, READ, CMP, DONE} state_t;

  localparam logic [A-1:0] ONE = {{(A-1){1'b0}}, 1'b1};

  state_t       state, state_nxt;
  logic [D-1:0] key_q, key_nxt;
  logic [A-1:0] addr, addr_nxt;
  logic         found_q, found_nxt;
  logic [A-1:0] faddr_q, faddr_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      key_q   <= '0;
      addr    <= '0;
      found_q <= 1'b0;
      faddr_q <= '0;
    end else begin
      state   <= state_nxt;
      key_q   <= key_nxt;
      addr    <= addr_nxt;
      found_q <= found_nxt;
      faddr_q <= faddr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    key_nxt   = key_q;
    addr_nxt  = addr;
    found_nxt = found_q;
    faddr_nxt = faddr_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          key_nxt   = bus.key;
          addr_nxt  = ONE;
          found_nxt = 1'b0;
          faddr_nxt = '0;
          state_nxt = READ;
        end
      end
      // The EMPTY-key bypass is decided on the registered key, so it costs one cycle.
      READ: state_nxt = (key_q == EMPTY) ? DONE : CMP;
      CMP: begin
        if (bus.mem_data == key_q) begin
          found_nxt = 1'b1;
          faddr_nxt = addr;
          state_nxt = DONE;
        end else if (bus.mem_data == EMPTY || addr[A-1]) begin
          state_nxt = DONE;
        end else begin
          addr_nxt  = {addr[A-2:0], (key_q > bus.mem_data)};
          state_nxt = READ;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // addr only moves on entry to READ, so it doubles as the held memory address.
  assign bus.mem_addr   = addr;
  assign bus.mem_rd     = (state == READ) && (key_q != EMPTY);
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.found      = found_q;
  assign bus.found_addr = faddr_q;

`ifdef TREE_SEARCH_STEP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      steps <= '0;
    end else if (state == IDLE && bus.start) begin
      steps <= '0;
    end else if (state == CMP) begin
      steps <= steps + ONE;
    end
  end
`endif

endmodule

// File: tb/tb_tree_search_ctrl.sv
// Scoreboard bench for tree_search_ctrl (A=3): expected reads and results are queued
// at issue time and checked by a monitor whenever mem_rd or done is seen.
module tb_tree_search_ctrl;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  tree_search_ctrl_if #(.D(8), .A(3)) bus ();

`ifdef TREE_SEARCH_STEP_CNT_EN
  logic [2:0] steps;
`endif

  tree_search_ctrl #(.D(8), .A(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef TREE_SEARCH_STEP_CNT_EN
    ,
    .steps (steps)
`endif
  );

  typedef struct {
    logic       f;
    logic [2:0] fa;
    int         lat;
    int         st;
    int         t0;
  } exp_t;

  exp_t       expq[$];
  int         rdq[$];
  logic [7:0] mem [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous node memory
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  exp_t mon_e;
  int   mon_a;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_rd) begin
        if (rdq.size() == 0) begin
          chk("unexpected_read_addr", {29'd0, bus.mem_addr}, 32'hFFFF_FFFF);
        end else begin
          mon_a = rdq.pop_front();
          chk("read_addr", {29'd0, bus.mem_addr}, mon_a);
        end
      end
      if (bus.done) begin
        if (expq.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = expq.pop_front();
          chk("done_latency", cyc - mon_e.t0 + 1, mon_e.lat);
          chk("found", {31'd0, bus.found}, {31'd0, mon_e.f});
          chk("found_addr", {29'd0, bus.found_addr}, {29'd0, mon_e.fa});
`ifdef TREE_SEARCH_STEP_CNT_EN
          chk("steps", {29'd0, steps}, mon_e.st);
`endif
        end
      end
    end
  end

  task automatic launch(input logic [7:0] k, input logic f, input logic [2:0] fa,
                        input int lat, input int st);
    exp_t e;
    e.f   = f;
    e.fa  = fa;
    e.lat = lat;
    e.st  = st;
    e.t0  = cyc + 1;
    expq.push_back(e);
    bus.key   = k;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic finish_search(input logic f, input logic [2:0] fa);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.done) seen = 1'b1;
      else @(negedge clk);
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
    chk("found_hold", {31'd0, bus.found}, {31'd0, f});
    chk("found_addr_hold", {29'd0, bus.found_addr}, {29'd0, fa});
    chk("busy_after_done", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},       {31'd0, bus.busy},       32'd0);
    chk({tag, "_done"},       {31'd0, bus.done},       32'd0);
    chk({tag, "_found"},      {31'd0, bus.found},      32'd0);
    chk({tag, "_mem_rd"},     {31'd0, bus.mem_rd},     32'd0);
    chk({tag, "_mem_addr"},   {29'd0, bus.mem_addr},   32'd0);
    chk({tag, "_found_addr"}, {29'd0, bus.found_addr}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.key   = 8'h00;
    for (int i = 0; i < 8; i++) mem[i] = 8'hFF;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    mem[1] = 8'h40; mem[2] = 8'h20; mem[3] = 8'h60;

    rdq = '{1};       launch(8'h40, 1'b1, 3'd1, 3, 1); finish_search(1'b1, 3'd1);
    rdq = '{1, 3};    launch(8'h60, 1'b1, 3'd3, 5, 2); finish_search(1'b1, 3'd3);
    rdq = '{1, 2, 5}; launch(8'h30, 1'b0, 3'd0, 7, 3); finish_search(1'b0, 3'd0);
    rdq = '{1, 2};    launch(8'h20, 1'b1, 3'd2, 5, 2); finish_search(1'b1, 3'd2);
    rdq.delete();     launch(8'hFF, 1'b0, 3'd0, 2, 0); finish_search(1'b0, 3'd0);

    // start re-pulsed with a different key while busy must not disturb the search
    rdq = '{1, 3};
    launch(8'h60, 1'b1, 3'd3, 5, 2);
    bus.start = 1'b1;
    bus.key   = 8'h20;
    @(negedge clk);
    bus.start = 1'b0;
    finish_search(1'b1, 3'd3);

    mem[4] = 8'h10; mem[5] = 8'h30; mem[6] = 8'h50; mem[7] = 8'h70;
    rdq = '{1, 3, 6}; launch(8'h50, 1'b1, 3'd6, 7, 3); finish_search(1'b1, 3'd6);
    rdq = '{1, 3, 7}; launch(8'h80, 1'b0, 3'd0, 7, 3); finish_search(1'b0, 3'd0);
    rdq = '{1, 2, 4}; launch(8'h05, 1'b0, 3'd0, 7, 3); finish_search(1'b0, 3'd0);

    // abort in CMP: extra start while busy, then asynchronous reset
    mem[1] = 8'h40; mem[2] = 8'h20; mem[3] = 8'h60;
    mem[4] = 8'hFF; mem[5] = 8'hFF; mem[6] = 8'hFF; mem[7] = 8'hFF;
    rdq = '{1};
    bus.key   = 8'h60;
    bus.start = 1'b1;
    @(negedge clk);
    bus.key = 8'h40;
    @(negedge clk);
    bus.start = 1'b0;
    chk("pre_reset_busy", {31'd0, bus.busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {31'd0, bus.busy}, 32'd0);

    rdq = '{1};       launch(8'h40, 1'b1, 3'd1, 3, 1); finish_search(1'b1, 3'd1);

    repeat (3) @(negedge clk);
    chk("pending_results", expq.size(), 32'd0);
    chk("pending_reads", rdq.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tree_search_ctrl.md
TREE_SEARCH_CTRL -- requirements
Module: tree_search_ctrl

Interface
REQ-001 Parameter D, default 8, key/data width in bits.
REQ-002 Parameter A, default 8, memory address width in bits.
REQ-003 Parameter EMPTY, default {D{1'b1}}, data value that marks an unoccupied tree node.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request a search; sampled only in IDLE.
REQ-007 key  input  D  search key; captured on the accepted start.
REQ-008 mem_addr  output  A  node address presented to the synchronous node memory.
REQ-009 mem_rd  output  1  memory read strobe; mem_data is valid the cycle after.
REQ-010 mem_data  input  D  node value returned by the memory.
REQ-011 busy  output  1  high from the cycle after start is accepted until done.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 found  output  1  result flag; valid while done=1 and held until the next accepted start.
REQ-014 found_addr  output  A  address of the matching node; 0 when found=0.

Function
REQ-015 The tree SHALL be heap-ordered: root at address 1, left child = addr<<1, right child = (addr<<1)|1.
REQ-016 States SHALL be IDLE, READ, CMP, DONE.
REQ-017 IDLE: on start=1 SHALL capture key, load addr=1, and go to READ; otherwise SHALL stay.
REQ-018 READ: SHALL drive mem_rd=1 with mem_addr=addr for exactly one cycle, then go to CMP.
REQ-019 CMP: mem_data==key SHALL set found=1, found_addr=addr, and go to DONE.
REQ-020 CMP: mem_data==EMPTY (and not equal to key) SHALL set found=0 and go to DONE.
REQ-021 CMP: key<mem_data (unsigned) SHALL set addr=addr<<1; key>mem_data SHALL set addr=(addr<<1)|1; then go to READ.
REQ-022 CMP: a mismatch while addr[A-1]=1 (last level) SHALL set found=0 and go to DONE, never wrapping the address.
REQ-023 DONE: SHALL assert done=1 for one cycle, then go to IDLE.
REQ-024 A start accepted with key==EMPTY SHALL go directly to DONE with found=0 and no memory read.
REQ-025 Latency: a hit at depth k (root k=1) SHALL raise done exactly 2k+1 cycles after the start-sampling edge.
REQ-026 start while busy SHALL be ignored; key changes after capture SHALL have no effect.
REQ-027 mem_rd SHALL be 0 and mem_addr SHALL hold its last value in all states except READ.

Reset
REQ-028 rst_n=0 SHALL asynchronously force IDLE with busy, done, found, mem_rd=0 and mem_addr, found_addr=0.
REQ-029 Reset asserted mid-search SHALL abort the search without emitting done; the first start after release SHALL begin a fresh search at root.

Configuration
REQ-030 Macro TREE_SEARCH_STEP_CNT_EN, when defined, SHALL add output steps (width A) counting CMP cycles of the current search, cleared on accepted start and held after done.
REQ-031 Without TREE_SEARCH_STEP_CNT_EN the steps port and counter SHALL not exist; all other behaviour is identical.

Verification
REQ-032 Memory {1:0x40,2:0x20,3:0x60,EMPTY elsewhere}, key=0x40 -> mem_rd at addr 1 only, done 3 cycles after start, found=1, found_addr=1.
REQ-033 Same memory, key=0x60 -> reads at addresses 1 then 3, done 5 cycles after start, found=1, found_addr=3 (steps=2 when the macro is defined).
REQ-034 Same memory, key=0x30 -> reads at 1, 2, 5; addr 5 returns EMPTY -> found=0, found_addr=0.
REQ-035 A=3, full tree with no match down the right spine -> reads at 1, 3, 7, then done with found=0 and no read at address 15/7 wrap.
REQ-036 Pulse start again while busy, then pull rst_n low during CMP -> second start ignored; reset aborts with no done, and all outputs=0 asynchronously.
REQ-037 key=EMPTY -> no mem_rd, done 2 cycles after start, found=0.
